// File: rtl/key_event_if.sv
// Event stream from key_event_queue to the host-interface logic.
// Handshake: an event transfers on a rising edge where event_valid_o and event_ready_i are both 1.
interface key_event_if #(
  parameter int DEPTH = 8
);
  logic                     event_valid_o;
  logic                     event_ready_i;
  logic [7:0]               event_code_o;
  logic [$clog2(DEPTH):0]   level_o;

  modport master (
    output event_valid_o,
    output event_code_o,
    output level_o,
    input  event_ready_i
  );

  modport slave (
    input  event_valid_o,
    input  event_code_o,
    input  level_o,
    output event_ready_i
  );
endinterface

// File: rtl/key_event_queue.sv
// Round-robin key scanner feeding a small event FIFO (press/release codes).
// Optional KEYQ_ANY_PRESSED_EN adds any_pressed_o, a registered "some key held" flag.
module key_event_queue #(
  parameter int KEYS  = 61,
  parameter int DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [KEYS-1:0]   keys_i,
`ifdef KEYQ_ANY_PRESSED_EN
  output logic              any_pressed_o,
`endif
  key_event_if.master       evt
);

  localparam int IDX_W = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [KEYS-1:0]  snap_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       head_q;

  logic             cur_key;
  logic             diff;
  logic             full;
  logic             push;
  logic             pop;
  logic [6:0]       idx_code;
  logic [7:0]       push_data;

  assign cur_key   = keys_i[idx_q];
  assign diff      = cur_key ^ snap_q[idx_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push      = diff && !full;
  assign pop       = evt.event_valid_o && evt.event_ready_i;
  assign idx_code  = 7'(idx_q);
  assign push_data = {~cur_key, idx_code};

  always_comb begin
    idx_next = idx_q;
    if (!diff || push) begin
      if (idx_q == IDX_W'(KEYS - 1)) idx_next = '0;
      else                           idx_next = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      snap_q <= '1;
      idx_q  <= '0;
    end else begin
      idx_q <= idx_next;
      if (push) snap_q[idx_q] <= cur_key;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // head_q is the registered FIFO head; when the only entry is popped while a
  // new one is pushed, the new entry is not in memory yet, so bypass it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop) begin
        if (count_q > CNT_W'(1)) head_q <= mem_q[PTR_W'(rd_ptr_q + 1'b1)];
        else if (push)           head_q <= push_data;
      end else if (push && (count_q == '0)) begin
        head_q <= push_data;
      end
    end
  end

  assign evt.event_valid_o = (count_q != '0);
  assign evt.event_code_o  = head_q;
  assign evt.level_o       = count_q;

`ifdef KEYQ_ANY_PRESSED_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) any_pressed_o <= 1'b0;
    else          any_pressed_o <= ~&snap_q;
  end
`endif

endmodule
